// File: rtl/conv_window_gen_pkg.sv
// rtl/conv_window_gen_pkg.sv - shared constants and types for the convolution window generator
package conv_window_gen_pkg;

  localparam int DATA_W   = 8;
  localparam int K        = 3;
  localparam int N_IN_DEF = 16;

  typedef logic signed [0:N_IN_DEF-1][DATA_W-1:0] pix_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } wg_state_e;

endpackage

// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel-in / window-out handshake bundle
// master is the window transmitter (the generator), slave is the pixel source / window consumer.
interface conv_window_gen_if
  import conv_window_gen_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int DATA_W = conv_window_gen_pkg::DATA_W,
  parameter int K      = conv_window_gen_pkg::K,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic signed [0:N_IN-1][DATA_W-1:0]         in_pix;
  logic                                       in_valid;
  logic                                       in_sof;
  logic                                       in_ready;
  logic signed [0:K*K-1][0:N_IN-1][DATA_W-1:0] window;
  logic                                       window_valid;
  logic                                       out_ready;
  logic [XW-1:0]                              out_x;
  logic [YW-1:0]                              out_y;
  logic                                       out_last;

  modport master (
    input  in_pix, in_valid, in_sof, out_ready,
    output in_ready, window, window_valid, out_x, out_y, out_last
  );

  modport slave (
    output in_pix, in_valid, in_sof, out_ready,
    input  in_ready, window, window_valid, out_x, out_y, out_last
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// rtl/conv_window_gen_line_buffer.sv - one image line of pixels, read-before-write at one address
// Read is combinational so the stored column enters the window on the same edge that overwrites it.
module conv_window_gen_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming KxK window generator with line buffers and frame coordinates
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int K      = conv_window_gen_pkg::K,
  parameter int DATA_W = conv_window_gen_pkg::DATA_W,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_window_gen_if.master bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = N_IN * DATA_W;

  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_EDGE     = XW'(K - 1);
  localparam logic [YW-1:0] Y_EDGE     = YW'(K - 1);
  localparam logic [YW-1:0] Y_FILL_END = YW'(K - 2);

  typedef logic signed [0:N_IN-1][DATA_W-1:0] lpix_t;

  wg_state_e     state, state_nxt;
  logic [XW-1:0] x_cnt, ex, x_nxt;
  logic [YW-1:0] y_cnt, ey, y_nxt;
  logic          rdy, accept, emit, frame_end;

  lpix_t lb_rd [K-1];
  lpix_t lb_wr [K-1];

  logic signed [0:K*K-1][0:N_IN-1][DATA_W-1:0] win_q;
  logic          wv_q, last_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;

  // in_sof re-anchors the accepted pixel at (0,0) regardless of where the counters were.
  always_comb begin
    ex        = bus.in_sof ? '0 : x_cnt;
    ey        = bus.in_sof ? '0 : y_cnt;
    frame_end = (ex == X_LAST) && (ey == Y_LAST);
    x_nxt     = (ex == X_LAST) ? '0 : ex + XW'(1);
    y_nxt     = ey;
    if (ex == X_LAST) y_nxt = (ey == Y_LAST) ? '0 : ey + YW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        FILL:    if (ex == X_LAST && ey == Y_FILL_END) state_nxt = STREAM;
        STREAM:  if (bus.in_sof || frame_end) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    rdy    = !wv_q || bus.out_ready;
    accept = bus.in_valid && rdy;
    emit   = accept && (state == STREAM) && (ex >= X_EDGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  // Line buffers form a vertical shift: buffer 0 holds the oldest line.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == K - 2) begin : g_top
      assign lb_wr[j] = bus.in_pix;
    end else begin : g_mid
      assign lb_wr[j] = lb_rd[j+1];
    end

    conv_window_gen_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (PW),
      .AW    (XW)
    ) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (ex),
      .wdata (lb_wr[j]),
      .rdata (lb_rd[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r*K+c] <= win_q[r*K+c+1];
      end
      for (int r = 0; r < K - 1; r++) win_q[r*K+K-1] <= lb_rd[r];
      win_q[K*K-1] <= bus.in_pix;
    end
  end

  // Accepts only happen when the pending window has been taken, so the window never moves while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wv_q   <= 1'b0;
      last_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else if (emit) begin
      wv_q   <= 1'b1;
      last_q <= frame_end;
      ox_q   <= ex - X_EDGE;
      oy_q   <= ey - Y_EDGE;
    end else if (bus.out_ready) begin
      wv_q   <= 1'b0;
    end
  end

  assign bus.in_ready     = rdy;
  assign bus.window       = win_q;
  assign bus.window_valid = wv_q;
  assign bus.out_x        = ox_q;
  assign bus.out_y        = oy_q;
  assign bus.out_last     = last_q;

endmodule
